// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter sharing four SRAM banks between the CPU and the Wishbone host.
// Each access is a fixed IDLE(grant) -> ISSUE -> CAPTURE sequence with a one-cycle ack.
module mem_bank_arbiter #(
    parameter int AW         = 9,
    parameter int DW         = 16,
    parameter bit LAST_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [AW+2:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_ack,
    output logic            cpu_wait,
    input  logic            host_req,
    input  logic            host_we,
    input  logic [AW+1:0]   host_addr,
    input  logic [DW-1:0]   host_wdata,
    output logic [DW-1:0]   host_rdata,
    output logic            host_ack,
    output logic [3:0]      mem_enb,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_rwb,
    input  logic [DW-1:0]   mem_rdata0,
    input  logic [DW-1:0]   mem_rdata1,
    input  logic [DW-1:0]   mem_rdata2,
    input  logic [DW-1:0]   mem_rdata3,
    output logic            busy,
    output logic            grant_host
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic           r_last;
    logic           r_owner;
    logic           r_we;
    logic [1:0]     r_bank;
    logic           r_oor;

    logic           w_cpu_elig;
    logic           w_host_elig;
    logic           w_grant;
    logic           w_pick_host;
    logic           w_sel_we;
    logic [1:0]     w_sel_bank;
    logic [AW-1:0]  w_sel_word;
    logic [DW-1:0]  w_sel_wdata;
    logic           w_sel_oor;
    logic [3:0]     w_sel_enb;
    logic [DW-1:0]  w_bank_rdata;

    // A requester whose ack is high is still dropping req and must not be re-granted.
    assign w_cpu_elig  = cpu_req & ~cpu_ack;
    assign w_host_elig = host_req & ~host_ack;
    assign cpu_wait    = cpu_req & ~cpu_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_grant     = 1'b0;
        w_pick_host = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cpu_elig && w_host_elig) begin
                    w_pick_host = ~r_last;
                end else begin
                    w_pick_host = w_host_elig;
                end
                w_grant = w_cpu_elig | w_host_elig;
                if (w_grant) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel_we    = w_pick_host ? host_we            : cpu_we;
        w_sel_bank  = w_pick_host ? host_addr[AW+1:AW] : cpu_addr[AW+1:AW];
        w_sel_word  = w_pick_host ? host_addr[AW-1:0]  : cpu_addr[AW-1:0];
        w_sel_wdata = w_pick_host ? host_wdata         : cpu_wdata;
        w_sel_oor   = ~w_pick_host & cpu_addr[AW+2];
        w_sel_enb   = w_sel_oor ? 4'hF : ~(4'b0001 << w_sel_bank);
    end

    always_comb begin
        w_bank_rdata = '0;
        if (!r_oor) begin
            case (r_bank)
                2'd0:    w_bank_rdata = mem_rdata0;
                2'd1:    w_bank_rdata = mem_rdata1;
                2'd2:    w_bank_rdata = mem_rdata2;
                default: w_bank_rdata = mem_rdata3;
            endcase
        end
    end

    // Memory-side outputs are launched from the grant cycle so they are registered in ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last     <= LAST_RESET;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_bank     <= 2'd0;
            r_oor      <= 1'b0;
            mem_enb    <= 4'hF;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rwb    <= 1'b1;
            cpu_rdata  <= '0;
            host_rdata <= '0;
            cpu_ack    <= 1'b0;
            host_ack   <= 1'b0;
            busy       <= 1'b0;
            grant_host <= 1'b0;
        end else begin
            cpu_ack  <= 1'b0;
            host_ack <= 1'b0;
            busy     <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner    <= w_pick_host;
                        r_we       <= w_sel_we;
                        r_bank     <= w_sel_bank;
                        r_oor      <= w_sel_oor;
                        mem_enb    <= w_sel_enb;
                        mem_addr   <= w_sel_word;
                        mem_wdata  <= w_sel_wdata;
                        mem_rwb    <= ~w_sel_we;
                        grant_host <= w_pick_host;
                    end
                end
                S_ISSUE: begin
                    mem_enb <= 4'hF;
                    mem_rwb <= 1'b1;
                end
                S_CAPTURE: begin
                    if (!r_we) begin
                        if (r_owner) begin
                            host_rdata <= w_bank_rdata;
                        end else begin
                            cpu_rdata <= w_bank_rdata;
                        end
                    end
                    if (r_owner) begin
                        host_ack <= 1'b1;
                    end else begin
                        cpu_ack <= 1'b1;
                    end
                    r_last <= r_owner;
                end
                default: begin
                    mem_enb <= 4'hF;
                    mem_rwb <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Directed bench for mem_bank_arbiter with a behavioural four-bank SRAM behind it.
module tb_mem_bank_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_wait;
    logic        host_req;
    logic        host_we;
    logic [10:0] host_addr;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic        host_ack;
    logic [3:0]  mem_enb;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rwb;
    logic [15:0] mem_rdata [4];
    logic        busy;
    logic        grant_host;

    logic [15:0] ram [4][512];

    int n_checks = 0;
    int n_fail   = 0;

    mem_bank_arbiter #(.AW(9), .DW(16), .LAST_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_wait   (cpu_wait),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .mem_enb    (mem_enb),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rwb    (mem_rwb),
        .mem_rdata0 (mem_rdata[0]),
        .mem_rdata1 (mem_rdata[1]),
        .mem_rdata2 (mem_rdata[2]),
        .mem_rdata3 (mem_rdata[3]),
        .busy       (busy),
        .grant_host (grant_host)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: read data appears the cycle after the enable.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!mem_enb[b]) begin
                if (!mem_rwb) ram[b][mem_addr] <= mem_wdata;
                mem_rdata[b] <= ram[b][mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_access(input bit host, input bit we, input logic [11:0] addr,
                             input logic [15:0] wd, input logic [3:0] exp_enb,
                             input logic [15:0] exp_rd, input string tag);
        @(posedge clk); #1;
        if (host) begin
            host_req = 1'b1; host_we = we; host_addr = addr[10:0]; host_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        @(negedge clk);
        chk({tag, ".c0_busy"}, busy, 0);
        chk({tag, ".c0_enb"}, mem_enb, 4'hF);
        if (!host) chk({tag, ".c0_wait"}, cpu_wait, 1);
        @(negedge clk);
        chk({tag, ".c1_enb"}, mem_enb, exp_enb);
        chk({tag, ".c1_addr"}, mem_addr, addr[8:0]);
        chk({tag, ".c1_rwb"}, mem_rwb, !we);
        chk({tag, ".c1_gh"}, grant_host, host);
        chk({tag, ".c1_busy"}, busy, 1);
        if (we) chk({tag, ".c1_wdata"}, mem_wdata, wd);
        if (!host) chk({tag, ".c1_wait"}, cpu_wait, 1);
        @(negedge clk);
        chk({tag, ".c2_enb"}, mem_enb, 4'hF);
        chk({tag, ".c2_rwb"}, mem_rwb, 1);
        if (!host) chk({tag, ".c2_wait"}, cpu_wait, 1);
        @(negedge clk);
        chk({tag, ".c3_cack"}, cpu_ack, !host);
        chk({tag, ".c3_hack"}, host_ack, host);
        chk({tag, ".c3_busy"}, busy, 0);
        if (!host) chk({tag, ".c3_wait"}, cpu_wait, 0);
        if (!we) chk({tag, ".c3_rdata"}, host ? host_rdata : cpu_rdata, exp_rd);
        @(posedge clk); #1;
        if (host) host_req = 1'b0; else cpu_req = 1'b0;
        @(negedge clk);
        chk({tag, ".c4_busy"}, busy, 0);
        chk({tag, ".c4_enb"}, mem_enb, 4'hF);
        chk({tag, ".c4_ack"}, cpu_ack | host_ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_enb", mem_enb, 4'hF);
        chk("rst_rwb", mem_rwb, 1);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_acks", {cpu_ack, host_ack}, 0);
        chk("rst_rdata", {cpu_rdata, host_rdata}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gh", grant_host, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Simultaneous requests right after reset: CPU first, then host
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
        host_req = 1; host_we = 1; host_addr = 11'h610; host_wdata = 16'h1234;
        @(negedge clk);
        chk("tie.c0_busy", busy, 0);
        @(negedge clk);
        chk("tie.c1_enb", mem_enb, 4'b1110);
        chk("tie.c1_addr", mem_addr, 9'h010);
        chk("tie.c1_rwb", mem_rwb, 1);
        chk("tie.c1_gh", grant_host, 0);
        @(negedge clk);
        chk("tie.c2_enb", mem_enb, 4'hF);
        @(negedge clk);
        chk("tie.c3_cack", cpu_ack, 1);
        chk("tie.c3_hack", host_ack, 0);
        @(posedge clk); #1;
        cpu_req = 0;
        @(negedge clk);
        chk("tie.c4_enb", mem_enb, 4'b0111);
        chk("tie.c4_addr", mem_addr, 9'h010);
        chk("tie.c4_rwb", mem_rwb, 0);
        chk("tie.c4_wdata", mem_wdata, 16'h1234);
        chk("tie.c4_gh", grant_host, 1);
        @(negedge clk);
        chk("tie.c5_enb", mem_enb, 4'hF);
        chk("tie.c5_ack", cpu_ack | host_ack, 0);
        @(negedge clk);
        chk("tie.c6_hack", host_ack, 1);
        chk("tie.c6_cack", cpu_ack, 0);
        @(posedge clk); #1;
        host_req = 0;
        @(negedge clk);
        chk("tie.c7_busy", busy, 0);

        // Continuous contention: 8 accesses alternating CPU/host
        cpu_we = 0; cpu_addr = 12'h010; host_we = 0; host_addr = 11'h610;
        for (int c = 0; c <= 25; c++) begin
            @(posedge clk); #1;
            cpu_req  = (c <= 21);
            host_req = (c <= 24);
            @(negedge clk);
            chk($sformatf("rr.c%0d_cack", c), cpu_ack, (c % 6 == 3));
            chk($sformatf("rr.c%0d_hack", c), host_ack, (c > 0 && c % 6 == 0));
            chk($sformatf("rr.c%0d_both", c), cpu_ack & host_ack, 0);
        end
        chk("rr.end_busy", busy, 0);
        @(posedge clk); #1;
        host_req = 0;

        // CPU write then read-back, bank 1
        do_access(0, 1, 12'h205, 16'hBEEF, 4'b1101, 16'h0000, "cw205");
        do_access(0, 0, 12'h205, 16'h0000, 4'b1101, 16'hBEEF, "cr205");
        do_access(1, 0, 12'h610, 16'h0000, 4'b0111, 16'h1234, "hr610");

        // Out-of-range CPU read
        do_access(0, 0, 12'h800, 16'h0000, 4'hF, 16'h0000, "cr800");

        // Reset during ISSUE of a host write
        @(posedge clk); #1;
        host_req = 1; host_we = 1; host_addr = 11'h123; host_wdata = 16'h5555;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid.issue_enb", mem_enb, 4'b1110);
        rst = 1'b0;
        #1;
        chk("rstmid.enb", mem_enb, 4'hF);
        chk("rstmid.busy", busy, 0);
        chk("rstmid.rwb", mem_rwb, 1);
        @(posedge clk); #1;
        chk("rstmid.hack", host_ack, 0);
        @(negedge clk);
        rst = 1'b1;
        chk("rstmid.c0_hack", host_ack, 0);
        @(negedge clk);
        chk("rstmid.c1_enb", mem_enb, 4'b1110);
        chk("rstmid.c1_addr", mem_addr, 9'h123);
        chk("rstmid.c1_rwb", mem_rwb, 0);
        @(negedge clk);
        chk("rstmid.c2_hack", host_ack, 0);
        @(negedge clk);
        chk("rstmid.c3_hack", host_ack, 1);
        @(posedge clk); #1;
        host_req = 0;
        do_access(1, 0, 12'h123, 16'h0000, 4'b1110, 16'h5555, "hr123");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
